// File: rtl/ct_hpcp_pkg.sv
// ---------------------------------------------------------------------------
// ct_hpcp_pkg
//  Shared definitions for the HPCP overflow-interrupt controller:
//   - HPCP_CNT_NUM_DFLT : default number of counters
//   - hpcp_state_e      : 2-bit request FSM encoding (HOLD only reachable
//                         when HPCP_INT_HOLDOFF_EN is defined)
//   - hpcp_clog2()      : ceil(log2(n)), never less than 1, so that index and
//                         counter vectors always have at least one bit
// ---------------------------------------------------------------------------
package ct_hpcp_pkg;

  localparam int HPCP_CNT_NUM_DFLT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WCLR = 2'd2,
    ST_HOLD = 2'd3
  } hpcp_state_e;

  function automatic int hpcp_clog2(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ct_hpcp_prio_enc.sv
// ---------------------------------------------------------------------------
// ct_hpcp_prio_enc
//  Combinational lowest-set-bit encoder.
//  Ports:
//   vec  in  CNT_NUM  candidate vector
//   idx  out IDX_W    index of the lowest set bit of vec (0 when vec == 0)
// ---------------------------------------------------------------------------
module ct_hpcp_prio_enc
  import ct_hpcp_pkg::*;
#(
  parameter int CNT_NUM = HPCP_CNT_NUM_DFLT,
  parameter int IDX_W   = hpcp_clog2(CNT_NUM)
) (
  input  logic [CNT_NUM-1:0] vec,
  output logic [IDX_W-1:0]   idx
);

  // Scan from the top down so the last (lowest) set bit wins.
  always_comb begin
    idx = '0;
    for (int i = CNT_NUM - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ct_hpcp_ovf_int_ctrl.sv
// ---------------------------------------------------------------------------
// ct_hpcp_ovf_int_ctrl
//  PMU counter-overflow interrupt controller. Holds the per-counter interrupt
//  enable vector and the sticky overflow-status vector, and runs a req/ack
//  handshake toward the interrupt controller.
//
//  Configuration macro: HPCP_INT_HOLDOFF_EN
//   defined   : after an ack the FSM sits in HOLD for HOLDOFF_CYC cycles
//               before a new event may re-raise the request.
//   undefined : ack moves straight to WCLR; no hold-off counter exists.
//
//  Ports:
//   hpcp_clk       in   1        clock
//   cpurst_b       in   1        asynchronous active-low reset
//   cntinten_wen   in   1        write strobe for the enable vector
//   cntovf_wen     in   1        write strobe for the overflow-status vector
//   hpcp_wdata     in   CNT_NUM  CSR write data
//   cnt_ovf_pulse  in   CNT_NUM  one-cycle overflow event per counter
//   hpcp_int_en    in   1        global interrupt gate
//   hpcp_int_ack   in   1        acknowledge from the interrupt controller
//   cntinten       out  CNT_NUM  enable vector
//   cntovf         out  CNT_NUM  sticky overflow status
//   hpcp_int_req   out  1        interrupt request (registered)
//   hpcp_int_idx   out  IDX_W    lowest pending counter index, latched on REQ entry
// ---------------------------------------------------------------------------
module ct_hpcp_ovf_int_ctrl
  import ct_hpcp_pkg::*;
#(
  parameter int CNT_NUM     = HPCP_CNT_NUM_DFLT,
  parameter int IDX_W       = hpcp_clog2(CNT_NUM),
  parameter int HOLDOFF_CYC = 16
) (
  input  logic               hpcp_clk,
  input  logic               cpurst_b,
  input  logic               cntinten_wen,
  input  logic               cntovf_wen,
  input  logic [CNT_NUM-1:0] hpcp_wdata,
  input  logic [CNT_NUM-1:0] cnt_ovf_pulse,
  input  logic               hpcp_int_en,
  input  logic               hpcp_int_ack,
  output logic [CNT_NUM-1:0] cntinten,
  output logic [CNT_NUM-1:0] cntovf,
  output logic               hpcp_int_req,
  output logic [IDX_W-1:0]   hpcp_int_idx
);

  logic [CNT_NUM-1:0] cntinten_reg;
  logic [CNT_NUM-1:0] cntovf_reg;
  logic [CNT_NUM-1:0] cntovf_next;
  logic [CNT_NUM-1:0] pend_vec;
  logic [CNT_NUM-1:0] new_vec;
  logic [CNT_NUM-1:0] relatch_vec;
  logic [IDX_W-1:0]   pend_idx;
  logic [IDX_W-1:0]   relatch_idx;
  logic [IDX_W-1:0]   int_idx_reg;
  logic [IDX_W-1:0]   int_idx_next;
  logic               int_req_reg;
  logic               pending;
  logic               new_evt;
  hpcp_state_e        state_reg;
  hpcp_state_e        state_next;

  // -------------------------------------------------------------------------
  // Enable and sticky status vectors. A hardware pulse is OR-ed in after the
  // software write so a same-cycle clear can never swallow an event.
  // -------------------------------------------------------------------------
  assign cntovf_next = cnt_ovf_pulse | (cntovf_wen ? hpcp_wdata : cntovf_reg);

  always_ff @(posedge hpcp_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cntinten_reg <= '0;
      cntovf_reg   <= '0;
    end else begin
      if (cntinten_wen) begin
        cntinten_reg <= hpcp_wdata;
      end
      cntovf_reg <= cntovf_next;
    end
  end

  // pending looks only at registered state; new_evt catches an enabled
  // counter whose status bit is about to go from 0 to 1 this cycle.
  assign pend_vec    = cntinten_reg & cntovf_reg;
  assign new_vec     = cnt_ovf_pulse & cntinten_reg & ~cntovf_reg;
  assign relatch_vec = pend_vec | new_vec;
  assign pending     = hpcp_int_en & (|pend_vec);
  assign new_evt     = hpcp_int_en & (|new_vec);

  // IDLE entry latches from the registered pending set; a re-request out of
  // WCLR/HOLD must also see the counter that is overflowing right now.
  ct_hpcp_prio_enc #(
    .CNT_NUM (CNT_NUM),
    .IDX_W   (IDX_W)
  ) u_enc_pend (
    .vec (pend_vec),
    .idx (pend_idx)
  );

  ct_hpcp_prio_enc #(
    .CNT_NUM (CNT_NUM),
    .IDX_W   (IDX_W)
  ) u_enc_relatch (
    .vec (relatch_vec),
    .idx (relatch_idx)
  );

`ifdef HPCP_INT_HOLDOFF_EN
  localparam int HOLD_W = hpcp_clog2(HOLDOFF_CYC);

  logic [HOLD_W-1:0] hold_cnt_reg;
  logic [HOLD_W-1:0] hold_cnt_next;
  logic              held_evt_reg;
  logic              held_evt_next;

  always_ff @(posedge hpcp_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      hold_cnt_reg <= '0;
      held_evt_reg <= 1'b0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      held_evt_reg <= held_evt_next;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Request FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    int_idx_next = int_idx_reg;
`ifdef HPCP_INT_HOLDOFF_EN
    hold_cnt_next = hold_cnt_reg;
    held_evt_next = held_evt_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (pending) begin
          state_next   = ST_REQ;
          int_idx_next = pend_idx;
        end
      end
      ST_REQ: begin
        if (!pending) begin
          state_next = ST_IDLE;
        end else if (hpcp_int_ack) begin
`ifdef HPCP_INT_HOLDOFF_EN
          state_next    = ST_HOLD;
          hold_cnt_next = HOLD_W'(HOLDOFF_CYC - 1);
          held_evt_next = 1'b0;
`else
          state_next = ST_WCLR;
`endif
        end
      end
      ST_WCLR: begin
        if (!pending) begin
          state_next = ST_IDLE;
        end else if (new_evt) begin
          state_next   = ST_REQ;
          int_idx_next = relatch_idx;
        end
      end
`ifdef HPCP_INT_HOLDOFF_EN
      ST_HOLD: begin
        // Events arriving while held off are remembered so that WCLR's
        // new-event rule still fires once the hold-off expires.
        if (!pending) begin
          state_next    = ST_IDLE;
          held_evt_next = 1'b0;
        end else if (hold_cnt_reg == '0) begin
          held_evt_next = 1'b0;
          if (new_evt || held_evt_reg) begin
            state_next   = ST_REQ;
            int_idx_next = relatch_idx;
          end else begin
            state_next = ST_WCLR;
          end
        end else begin
          hold_cnt_next = hold_cnt_reg - 1'b1;
          held_evt_next = held_evt_reg | new_evt;
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge hpcp_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_reg   <= ST_IDLE;
      int_req_reg <= 1'b0;
      int_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      int_req_reg <= (state_next == ST_REQ);
      int_idx_reg <= int_idx_next;
    end
  end

  assign cntinten     = cntinten_reg;
  assign cntovf       = cntovf_reg;
  assign hpcp_int_req = int_req_reg;
  assign hpcp_int_idx = int_idx_reg;

endmodule
